// File: rtl/anim_pkg.sv
// Shared animation definitions so the scheduler and the frame memories agree
// on state encoding, the idle select code and the default step width.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int ANIM_IDLE      = 0;
  localparam int FRAMES_DEFAULT = 16;

endpackage

// File: rtl/anim_prio_enc.sv
// Lowest-index-wins pick over the pending request vector: valid flag,
// one-hot grant mask and binary index of the winner.
module anim_prio_enc #(
  parameter int N_ANIM = 4,
  parameter int IDX_W  = 2
) (
  input  logic [N_ANIM-1:0] pend,
  output logic              valid,
  output logic [N_ANIM-1:0] grant_oh,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    valid    = |pend;
    grant_oh = '0;
    idx      = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_ANIM - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        idx         = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/anim_scheduler.sv
// Animation sequencer: idle loop by default, plays granted event animations
// for LOOPS passes, holds the last frame, then idles or chains the next one.
module anim_scheduler
  import anim_pkg::*;
#(
  parameter int N_ANIM     = 4,
  parameter int FRAMES     = FRAMES_DEFAULT,
  parameter int LOOPS      = 2,
  parameter int HOLD_TICKS = 4
) (
  input  logic                         clk_24,
  input  logic                         rst,
  input  logic [N_ANIM-1:0]            req,
  input  logic                         cancel,
  output logic [$clog2(N_ANIM+1)-1:0]  anim_sel,
  output logic [$clog2(FRAMES)-1:0]    step,
  output logic                         busy,
  output logic                         done,
  output logic [N_ANIM-1:0]            pending
);

  localparam int SEL_W  = $clog2(N_ANIM + 1);
  localparam int STEP_W = $clog2(FRAMES);
  localparam int IDX_W  = (N_ANIM > 1) ? $clog2(N_ANIM) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAMES - 1);
  localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [SEL_W-1:0]  SEL_IDLE  = SEL_W'(ANIM_IDLE);

  state_t              state;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                pick_vld;
  logic [N_ANIM-1:0]   pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                idle_wrap;
  logic                hold_last;
  logic                fire_grant;
  logic [N_ANIM-1:0]   grant_mask;
  logic [SEL_W-1:0]    grant_sel;

  anim_prio_enc #(
    .N_ANIM (N_ANIM),
    .IDX_W  (IDX_W)
  ) u_prio (
    .pend     (pending),
    .valid    (pick_vld),
    .grant_oh (pick_oh),
    .idx      (pick_idx)
  );

  assign idle_wrap  = (state == IDLE) && (step == LAST_STEP);
  assign hold_last  = (state == HOLD) && (hold_cnt == LAST_HOLD);
  // Grants only happen at the idle wrap or hold exit, and never under cancel.
  assign fire_grant = pick_vld && !cancel && (idle_wrap || hold_last);
  assign grant_mask = fire_grant ? pick_oh : '0;
  assign grant_sel  = SEL_W'(pick_idx) + SEL_W'(1);

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      anim_sel <= SEL_IDLE;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= '0;
      loop_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      done    <= 1'b0;
      pending <= cancel ? '0 : ((pending | req) & ~grant_mask);
      if (cancel && state != IDLE) begin
        state    <= IDLE;
        anim_sel <= SEL_IDLE;
        step     <= '0;
        busy     <= 1'b0;
        loop_cnt <= '0;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (step == LAST_STEP) begin
              step <= '0;
              if (fire_grant) begin
                state    <= PLAY;
                anim_sel <= grant_sel;
                loop_cnt <= '0;
                busy     <= 1'b1;
              end
            end else begin
              step <= step + STEP_W'(1);
            end
          end
          PLAY: begin
            if (step == LAST_STEP) begin
              if (loop_cnt == LAST_LOOP) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else begin
                step     <= '0;
                loop_cnt <= loop_cnt + LOOP_W'(1);
              end
            end else begin
              step <= step + STEP_W'(1);
            end
          end
          HOLD: begin
            if (hold_cnt == LAST_HOLD) begin
              done     <= 1'b1;
              step     <= '0;
              hold_cnt <= '0;
              if (fire_grant) begin
                state    <= PLAY;
                anim_sel <= grant_sel;
                loop_cnt <= '0;
              end else begin
                state    <= IDLE;
                anim_sel <= SEL_IDLE;
                busy     <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          default: begin
            state    <= IDLE;
            anim_sel <= SEL_IDLE;
            step     <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed bench for anim_scheduler at default parameters; observed outputs
// are packed as {anim_sel, step, busy, done, pending}.
module tb_anim_scheduler;

  logic       clk_24 = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       cancel;
  logic [2:0] anim_sel;
  logic [3:0] step;
  logic       busy;
  logic       done;
  logic [3:0] pending;
  logic [12:0] obs;

  int errors = 0;
  int total  = 0;

  anim_scheduler dut (
    .clk_24   (clk_24),
    .rst      (rst),
    .req      (req),
    .cancel   (cancel),
    .anim_sel (anim_sel),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .pending  (pending)
  );

  always #5 clk_24 = ~clk_24;

  assign obs = {anim_sel, step, busy, done, pending};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_24);
      #1;
    end
  endtask

  task automatic wait_step(input logic [3:0] val);
    int n;
    n = 0;
    while (step !== val && n < 64) begin
      tick(1);
      n++;
    end
    total++;
    if (step !== val) begin
      $display("FAIL wait_step timeout got step=%0d want %0d", step, val);
      errors++;
    end
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst = 1'b1; req = '0; cancel = 1'b0;
    #3;
    total++;
    if (obs !== 13'd0) begin
      $display("FAIL reset_async got %h want %h", obs, 13'd0); errors++;
    end
    @(posedge clk_24); #1;
    rst = 1'b0;
    total++;
    if (obs !== 13'd0) begin
      $display("FAIL reset_hold got %h want %h", obs, 13'd0); errors++;
    end
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      exp = {3'd0, 4'(i % 16), 1'b0, 1'b0, 4'b0000};
      total++;
      if (obs !== exp) begin
        $display("FAIL idle_wrap[%0d] got %h want %h", i, obs, exp); errors++;
      end
    end
  endtask

  task automatic test_single();
    wait_step(4'd3);
    req = 4'b0100; tick(1); req = '0;
    total++;
    if (obs !== {3'd0, 4'd4, 1'b0, 1'b0, 4'b0100}) begin
      $display("FAIL single_latch got %h want %h", obs, {3'd0, 4'd4, 1'b0, 1'b0, 4'b0100}); errors++;
    end
    tick(11);
    total++;
    if (obs !== {3'd0, 4'd15, 1'b0, 1'b0, 4'b0100}) begin
      $display("FAIL single_pregrant got %h want %h", obs, {3'd0, 4'd15, 1'b0, 1'b0, 4'b0100}); errors++;
    end
    tick(1);
    total++;
    if (obs !== {3'd3, 4'd0, 1'b1, 1'b0, 4'b0000}) begin
      $display("FAIL single_grant got %h want %h", obs, {3'd3, 4'd0, 1'b1, 1'b0, 4'b0000}); errors++;
    end
    tick(31);
    total++;
    if (obs !== {3'd3, 4'd15, 1'b1, 1'b0, 4'b0000}) begin
      $display("FAIL single_playend got %h want %h", obs, {3'd3, 4'd15, 1'b1, 1'b0, 4'b0000}); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if (obs !== {3'd3, 4'd15, 1'b1, 1'b0, 4'b0000}) begin
        $display("FAIL single_hold[%0d] got %h want %h", i, obs, {3'd3, 4'd15, 1'b1, 1'b0, 4'b0000}); errors++;
      end
    end
    tick(1);
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}) begin
      $display("FAIL single_done got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}); errors++;
    end
    tick(1);
    total++;
    if (obs !== {3'd0, 4'd1, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL single_after got %h want %h", obs, {3'd0, 4'd1, 1'b0, 1'b0, 4'b0000}); errors++;
    end
  endtask

  task automatic test_back_to_back();
    wait_step(4'd3);
    req = 4'b1010; tick(1); req = '0;
    tick(11);
    tick(1);
    total++;
    if (obs !== {3'd2, 4'd0, 1'b1, 1'b0, 4'b1000}) begin
      $display("FAIL chain_grant1 got %h want %h", obs, {3'd2, 4'd0, 1'b1, 1'b0, 4'b1000}); errors++;
    end
    tick(35);
    total++;
    if (obs !== {3'd2, 4'd15, 1'b1, 1'b0, 4'b1000}) begin
      $display("FAIL chain_hold1 got %h want %h", obs, {3'd2, 4'd15, 1'b1, 1'b0, 4'b1000}); errors++;
    end
    tick(1);
    total++;
    if (obs !== {3'd4, 4'd0, 1'b1, 1'b1, 4'b0000}) begin
      $display("FAIL chain_grant2 got %h want %h", obs, {3'd4, 4'd0, 1'b1, 1'b1, 4'b0000}); errors++;
    end
    tick(1);
    total++;
    if (obs !== {3'd4, 4'd1, 1'b1, 1'b0, 4'b0000}) begin
      $display("FAIL chain_play2 got %h want %h", obs, {3'd4, 4'd1, 1'b1, 1'b0, 4'b0000}); errors++;
    end
    tick(34);
    total++;
    if (obs !== {3'd4, 4'd15, 1'b1, 1'b0, 4'b0000}) begin
      $display("FAIL chain_hold2 got %h want %h", obs, {3'd4, 4'd15, 1'b1, 1'b0, 4'b0000}); errors++;
    end
    tick(1);
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}) begin
      $display("FAIL chain_done2 got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}); errors++;
    end
  endtask

  task automatic test_collision();
    wait_step(4'd3);
    req = 4'b0001; tick(1);
    total++;
    if (obs !== {3'd0, 4'd4, 1'b0, 1'b0, 4'b0001}) begin
      $display("FAIL coll_latch got %h want %h", obs, {3'd0, 4'd4, 1'b0, 1'b0, 4'b0001}); errors++;
    end
    tick(11);
    tick(1);
    req = '0;
    total++;
    if (obs !== {3'd1, 4'd0, 1'b1, 1'b0, 4'b0000}) begin
      $display("FAIL coll_grant got %h want %h", obs, {3'd1, 4'd0, 1'b1, 1'b0, 4'b0000}); errors++;
    end
    tick(36);
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}) begin
      $display("FAIL coll_done got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b1, 4'b0000}); errors++;
    end
    tick(16);
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL coll_noreplay got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}); errors++;
    end
  endtask

  task automatic test_cancel_play();
    wait_step(4'd3);
    req = 4'b0100; tick(1); req = '0;
    tick(12);
    req = 4'b0001; tick(1); req = '0;
    total++;
    if (obs !== {3'd3, 4'd1, 1'b1, 1'b0, 4'b0001}) begin
      $display("FAIL cancel_prepend got %h want %h", obs, {3'd3, 4'd1, 1'b1, 1'b0, 4'b0001}); errors++;
    end
    tick(22);
    total++;
    if (obs !== {3'd3, 4'd7, 1'b1, 1'b0, 4'b0001}) begin
      $display("FAIL cancel_pre got %h want %h", obs, {3'd3, 4'd7, 1'b1, 1'b0, 4'b0001}); errors++;
    end
    cancel = 1'b1; tick(1); cancel = 1'b0;
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL cancel_play got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}); errors++;
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      total++;
      if (obs !== {3'd0, 4'(i), 1'b0, 1'b0, 4'b0000}) begin
        $display("FAIL cancel_after[%0d] got %h want %h", i, obs, {3'd0, 4'(i), 1'b0, 1'b0, 4'b0000}); errors++;
      end
    end
  endtask

  task automatic test_cancel_idle();
    wait_step(4'd3);
    req = 4'b0010; tick(1);
    total++;
    if (obs !== {3'd0, 4'd4, 1'b0, 1'b0, 4'b0010}) begin
      $display("FAIL cidle_latch got %h want %h", obs, {3'd0, 4'd4, 1'b0, 1'b0, 4'b0010}); errors++;
    end
    req = 4'b0001; cancel = 1'b1; tick(1); req = '0; cancel = 1'b0;
    total++;
    if (obs !== {3'd0, 4'd5, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL cidle_flush got %h want %h", obs, {3'd0, 4'd5, 1'b0, 1'b0, 4'b0000}); errors++;
    end
    tick(11);
    total++;
    if (obs !== {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL cidle_nogrant got %h want %h", obs, {3'd0, 4'd0, 1'b0, 1'b0, 4'b0000}); errors++;
    end
  endtask

  task automatic test_async_reset();
    wait_step(4'd3);
    req = 4'b0001; tick(1); req = '0;
    tick(12);
    tick(33);
    req = 4'b0010; tick(1); req = '0;
    total++;
    if (obs !== {3'd1, 4'd15, 1'b1, 1'b0, 4'b0010}) begin
      $display("FAIL arst_pre got %h want %h", obs, {3'd1, 4'd15, 1'b1, 1'b0, 4'b0010}); errors++;
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 13'd0) begin
      $display("FAIL arst_mid got %h want %h", obs, 13'd0); errors++;
    end
    rst = 1'b0;
    tick(1);
    total++;
    if (obs !== {3'd0, 4'd1, 1'b0, 1'b0, 4'b0000}) begin
      $display("FAIL arst_resume got %h want %h", obs, {3'd0, 4'd1, 1'b0, 1'b0, 4'b0000}); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_collision();
    test_cancel_play();
    test_cancel_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
